// File: rtl/demux_8_pkg.sv
// Shared constants and helpers for the 8-channel banked demultiplexer.
package demux_8_pkg;

  localparam int unsigned NCH      = 8;
  localparam int unsigned SEL_W    = 3;
  localparam logic [7:0]  DROP_MAX = 8'd255;

  function automatic logic [NCH-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    logic [NCH-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a single output channel of the demux bank.
module demux_slot #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             ack,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  // A reload wins over an ack on the same edge so a draining consumer sees no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      valid <= 1'b1;
    end else if (ack && valid) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_8_bank.sv
// Routes one input word to one or all of eight holding channels; counts stalled cycles.
module demux_8_bank
  import demux_8_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [SEL_W-1:0]     in_sel,
  input  logic                 in_bcast,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic [NCH-1:0]       out_valid,
  input  logic [NCH-1:0]       out_ack,
  output logic [7:0]           drop_cnt
);

  logic [NCH-1:0] free;
  logic [NCH-1:0] load;
  logic           xfer;

  // A channel can take a word if it is empty or is being drained this edge.
  always_comb begin
    free     = ~out_valid | out_ack;
    in_ready = in_bcast ? (&free) : free[in_sel];
    xfer     = in_valid & in_ready;
    load     = '0;
    if (xfer) begin
      load = in_bcast ? {NCH{1'b1}} : sel_onehot(in_sel);
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_slot
    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load[k]),
      .ack      (out_ack[k]),
      .load_data(in_data),
      .data     (out_data[k*WIDTH +: WIDTH]),
      .valid    (out_valid[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (in_valid && !in_ready && (drop_cnt != DROP_MAX)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: doc/demux_8_bank.md
DEMUX_8_BANK -- requirements
Module: demux_8_bank

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the data width of the input and of each output channel.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_data  input  WIDTH  data word to be routed.
REQ-005 in_sel  input  3  destination channel index, 0..7.
REQ-006 in_bcast  input  1  when 1, in_sel is ignored and the word goes to all 8 channels.
REQ-007 in_valid  input  1  producer offers in_data this cycle.
REQ-008 in_ready  output  1  block accepts in_data this cycle.
REQ-009 out_data  output  8*WIDTH  channel k data at bits [k*WIDTH +: WIDTH].
REQ-010 out_valid  output  8  bit k set means channel k holds an unconsumed word.
REQ-011 out_ack  input  8  bit k: consumer k takes its word this cycle.
REQ-012 drop_cnt  output  8  saturating count of cycles with in_valid=1 and in_ready=0.

Function
REQ-013 Each channel SHALL be a one-entry holding register with a valid flag.
REQ-014 A transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1.
REQ-015 Unicast (in_bcast=0): in_ready SHALL be 1 when out_valid[in_sel]=0 or out_ack[in_sel]=1.
REQ-016 Broadcast (in_bcast=1): in_ready SHALL be 1 only when every channel k has out_valid[k]=0 or out_ack[k]=1.
REQ-017 in_ready SHALL be combinational from in_sel, in_bcast, out_valid and out_ack; it SHALL NOT depend on in_valid.
REQ-018 Latency: a word accepted at edge N SHALL appear on its channel(s) with out_valid=1 from edge N onward, i.e. visible in cycle N+1.
REQ-019 A consumer ack SHALL take effect on a rising edge where out_valid[k]=1 and out_ack[k]=1, clearing out_valid[k] unless the same edge reloads channel k.
REQ-020 Simultaneous ack and transfer to the same channel SHALL reload the data, and out_valid[k] SHALL stay 1 with no bubble.
REQ-021 out_ack[k]=1 while out_valid[k]=0 SHALL be ignored.
REQ-022 out_data for a channel SHALL hold its value until that channel is reloaded; it SHALL NOT change on ack alone.
REQ-023 Channels not addressed by a transfer SHALL keep their data and valid flag.
REQ-024 drop_cnt SHALL increment by 1 per stalled cycle (in_valid=1, in_ready=0) and saturate at 255.
REQ-025 in_sel SHALL be treated as unsigned modulo 8; every value maps to a channel, and no high-impedance output exists.

Reset
REQ-026 While rst_n=0, out_valid SHALL be 8'h00, out_data all zero and drop_cnt 0, regardless of clk.
REQ-027 Reset asserted mid-operation SHALL discard all held words; no pending word SHALL survive reset.
REQ-028 Deassertion of rst_n SHALL be synchronised by the integrator. The first transfer SHALL be possible on the first rising edge after deassertion.

Structure
REQ-029 Shared package demux_8_pkg SHALL hold NCH=8, SEL_W=3 and DROP_MAX=255.
REQ-030 Sub-module demux_slot (one-entry register: load, ack, data, valid) SHALL be instantiated NCH times.
REQ-031 Top level SHALL contain only the ready/load decode and drop_cnt.

Verification
REQ-032 Reset, then unicast in_data=8'hA5, in_sel=3 -> next cycle out_valid=8'h08, channel 3 data=8'hA5, others 0.
REQ-033 Channel 3 full with no ack, second word to sel=3 held valid for 4 cycles -> in_ready=0 for all 4, drop_cnt=4; then ack -> transfer on that edge.
REQ-034 Channel 5 full, same cycle out_ack[5]=1 and new word 8'h3C to sel=5 -> out_valid[5] stays 1, data becomes 8'h3C.
REQ-035 Broadcast 8'h77 with all channels empty -> out_valid=8'hFF, all channels 8'h77; repeat with channel 0 full and unacked -> in_ready=0.
REQ-036 Load channels 1 and 6, assert rst_n=0 between clock edges -> out_valid=8'h00 and data zero immediately, without a clock edge.
REQ-037 Hold in_valid=1 with blocked channel for 300 cycles -> drop_cnt=255, no wrap.
